fifo_stream_reader: RTL and testbench

- Read-side stage placed directly downstream of the synchronous FIFO (synch_FIFO).
- Issues FIFO read enables, absorbs the FIFO's 1-cycle registered read latency and presents the words as a valid/ready stream.
- Holds words in a 2-entry output buffer so the stream sustains 1 word/cycle under backpressure.
- Frames the stream into fixed-length bursts (m_last) and counts delivered words.

---
 rtl/fifo_stream_reader.sv | 130 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for synch_FIFO: absorbs the FIFO's registered read latency,
// buffers two words and presents a burst-framed valid/ready stream.
// Optional macro FIFO_STREAM_READER_PARITY_EN adds m_parity (even parity of m_data).
//
// Buffer occupancy (count, inflight adds a pending word on top):
//   state   | meaning
//   0       | no word held, m_valid low, m_data keeps last value
//   1       | head word in slot0
//   2       | slot0 head, slot1 next; reads stop unless a pop frees room
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  words_out
`ifdef FIFO_STREAM_READER_PARITY_EN
    ,
    output logic                  m_parity
`endif
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [1:0]            count;
    logic                  inflight;
    logic [BEAT_W-1:0]     beat_idx;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pop;
    logic [2:0]            occ;

    assign m_valid = (count != 2'd0);
    assign m_data  = slot0;
    assign pop     = m_valid & m_ready;
    assign m_last  = m_valid & (beat_idx == LAST_BEAT);

    // Occupancy after this edge, counting the word already on its way from the FIFO.
    assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = rst & ~fifo_empty & (occ < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= 1'b0;
            beat_idx  <= '0;
            words_out <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                words_out <= words_out + CNT_WIDTH'(1);
                beat_idx  <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + BEAT_W'(1);
            end
        end
    end

    // slot0 only shifts when a second word exists, so m_data holds while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= fifo_data;
                    else               slot1 <= fifo_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= fifo_data;
                    end else begin
                        slot0 <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_PARITY_EN
    logic par0;
    logic par1;
    logic cap_par;

    assign cap_par  = ^fifo_data;
    assign m_parity = par0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par0 <= 1'b0;
            par1 <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) par0 <= cap_par;
                    else               par1 <= cap_par;
                end
                2'b01: begin
                    if (count == 2'd2) par0 <= par1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        par0 <= par1;
                        par1 <= cap_par;
                    end else begin
                        par0 <= cap_par;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model plus a counting reference of reads,
// pops and in-order words, driven by directed scenarios and random traffic.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] words_out;
`ifdef FIFO_STREAM_READER_PARITY_EN
    logic          m_parity;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .words_out  (words_out)
`ifdef FIFO_STREAM_READER_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            reads;
    int            pops;
    int            rd_total;
    logic          last_rd;
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    int            n_vec;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check before posedge, advance model after it.
    task automatic step(input logic rdy, input logic rst_v, input bit clr_fifo);
        logic ev;
        logic er;
        logic pop_e;
        logic rd;
        @(negedge clk);
        m_ready = rdy;
        rst     = rst_v;
        #1;
        rd    = fifo_rd_en;
        pop_e = 1'b0;
        if (!rst_v) begin
            chk("rst_rd_en", rd, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
            chk("rst_words", words_out, 0);
        end else begin
            ev    = (reads - int'(last_rd) - pops) > 0;
            pop_e = ev && rdy;
            er    = !fifo_empty && ((reads - pops - int'(pop_e)) < 2);
            chk("valid", m_valid, ev);
            chk("rd_en", rd, er);
            chk("words_out", words_out, pops % (1 << CW));
            if (ev && exp_q.size() != 0) begin
                chk("data", m_data, exp_q[0]);
                chk("last", m_last, (pops % BL) == BL - 1);
`ifdef FIFO_STREAM_READER_PARITY_EN
                chk("parity", m_parity, ^exp_q[0]);
`endif
            end else begin
                chk("last_idle", m_last, 0);
            end
            if (prev_stall) chk("hold_data", m_data, prev_d);
            prev_stall = ev && !rdy;
            prev_d     = ev && exp_q.size() != 0 ? exp_q[0] : prev_d;
            if (pop_e && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (!rst_v) begin
            reads      = 0;
            pops       = 0;
            last_rd    = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
            if (clr_fifo) fifo_q.delete();
        end else begin
            if (pop_e) pops++;
            last_rd = rd && fifo_q.size() != 0;
            if (last_rd) begin
                reads++;
                rd_total++;
                fifo_data = fifo_q.pop_front();
                exp_q.push_back(fifo_data);
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic preload(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
        fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; reads = 0; pops = 0; rd_total = 0;
        last_rd = 1'b0; prev_stall = 1'b0; prev_d = '0;

        // Reset with a non-empty FIFO, then stream 0..15
        preload(0, 16);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        rd_total = 0;
        repeat (20) step(1'b1, 1'b1, 1'b0);
        chk("stream_reads", rd_total, 16);
        chk("stream_pops", pops, 16);

        // Backpressure: only two reads while stalled, then alternate ready
        step(1'b0, 1'b0, 1'b1);
        preload(0, 8);
        rd_total = 0;
        repeat (6) step(1'b0, 1'b1, 1'b0);
        chk("bp_reads", rd_total, 2);
        chk("bp_head", m_data, 0);
        for (int i = 0; i < 30; i++) step((i % 2) == 0, 1'b1, 1'b0);
        chk("bp_pops", pops, 8);
        chk("bp_fifo_empty", fifo_q.size(), 0);

        // Single word: FIFO goes empty with the read in flight
        step(1'b0, 1'b0, 1'b1);
        fifo_q.push_back(8'hA5);
        fifo_empty = 1'b0;
        rd_total = 0;
        repeat (8) step(1'b1, 1'b1, 1'b0);
        chk("single_reads", rd_total, 1);
        chk("single_pops", pops, 1);
        chk("single_valid", m_valid, 0);

        // Reset mid-burst, then a fresh burst must frame from beat 0
        step(1'b0, 1'b0, 1'b1);
        preload(8'h10, 8);
        for (int i = 0; i < 12 && pops < 2; i++) step(1'b1, 1'b1, 1'b0);
        chk("mid_pops", pops, 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_valid", m_valid, 0);
        chk("mid_words", words_out, 0);
        preload(8'h40, 8);
        repeat (12) step(1'b1, 1'b1, 1'b0);
        chk("mid_next_pops", pops, 8);

        // Counter wrap at CNT_WIDTH=4: 17 pops leave words_out = 1
        step(1'b0, 1'b0, 1'b1);
        preload(8'h01, 17);
        repeat (25) step(1'b1, 1'b1, 1'b0);
        chk("wrap_words", words_out, 1);

        // Random traffic and backpressure
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) begin
                fifo_q.push_back(DW'($urandom));
                fifo_empty = 1'b0;
            end
            step($urandom_range(0, 3) != 0, 1'b1, 1'b0);
        end
        repeat (25) step(1'b1, 1'b1, 1'b0);
        chk("rand_drained", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
